// File: rtl/dither_pkg.sv
// dither_pkg: shared constants, types and helpers for the Floyd-Steinberg
// dither engine.
//   - default frame geometry
//   - diffusion weights (7, 3, 5, 1) and the shift that divides by 16
//   - thresholds and output levels for the 1-bit and 2-bit quantizers
//     (the 2-bit set is used when DITHER_2BIT_EN is defined)
//   - err_t / acc_t signed types, clamp-to-8-bit and weighted-diffusion helpers
package dither_pkg;

  localparam int DEF_FRAME_WIDTH  = 320;
  localparam int DEF_FRAME_HEIGHT = 240;

  localparam logic [3:0] K_RIGHT      = 4'd7;
  localparam logic [3:0] K_DOWN_LEFT  = 4'd3;
  localparam logic [3:0] K_DOWN       = 4'd5;
  localparam logic [3:0] K_DOWN_RIGHT = 4'd1;
  localparam int         DIFF_SHIFT   = 4;

  localparam logic [7:0] TH_1BIT     = 8'd128;
  localparam logic [7:0] LVL_1BIT_LO = 8'd0;
  localparam logic [7:0] LVL_1BIT_HI = 8'd255;

  localparam logic [7:0] TH_2BIT_0  = 8'd43;
  localparam logic [7:0] TH_2BIT_1  = 8'd128;
  localparam logic [7:0] TH_2BIT_2  = 8'd213;
  localparam logic [7:0] LVL_2BIT_0 = 8'd0;
  localparam logic [7:0] LVL_2BIT_1 = 8'd85;
  localparam logic [7:0] LVL_2BIT_2 = 8'd170;
  localparam logic [7:0] LVL_2BIT_3 = 8'd255;

  typedef logic signed [8:0]  err_t;
  typedef logic signed [12:0] acc_t;

  function automatic logic [7:0] clamp8(input logic signed [13:0] x);
    if (x < 14'sd0) begin
      return 8'd0;
    end else if (x > 14'sd255) begin
      return 8'd255;
    end else begin
      return x[7:0];
    end
  endfunction

  // err * k as a signed 13-bit product, then an arithmetic shift (floor /16)
  function automatic acc_t diffuse(input err_t e, input logic [3:0] k);
    acc_t prod;
    prod = $signed({{4{e[8]}}, e}) * $signed({9'd0, k});
    return prod >>> DIFF_SHIFT;
  endfunction

endpackage

// File: rtl/dither_quantizer.sv
// dither_quantizer: maps a clamped pixel value to its output level and
// reports the quantization error.
//   v_i   [7:0]  clamped pixel value
//   q_o   [7:0]  quantized level
//   err_o [8:0]  signed error v_i - q_o
// Build option: DITHER_2BIT_EN selects the 4-level quantizer {0,85,170,255};
// otherwise a 1-bit threshold at 128 is used.
module dither_quantizer
  import dither_pkg::*;
(
  input  logic [7:0]        v_i,
  output logic [7:0]        q_o,
  output logic signed [8:0] err_o
);

  always_comb begin
    q_o = LVL_1BIT_LO;
`ifdef DITHER_2BIT_EN
    if (v_i < TH_2BIT_0) begin
      q_o = LVL_2BIT_0;
    end else if (v_i < TH_2BIT_1) begin
      q_o = LVL_2BIT_1;
    end else if (v_i < TH_2BIT_2) begin
      q_o = LVL_2BIT_2;
    end else begin
      q_o = LVL_2BIT_3;
    end
`else
    q_o = (v_i >= TH_1BIT) ? LVL_1BIT_HI : LVL_1BIT_LO;
`endif
    err_o = $signed({1'b0, v_i}) - $signed({1'b0, q_o});
  end

endmodule

// File: rtl/dither_engine.sv
// dither_engine: Floyd-Steinberg error diffusion between the line buffers and
// the palette stage. Two-stage pipeline: inputs are registered, then the
// quantize/diffuse step runs against the carry and next-row accumulators.
//   clk_in, rst_in (async, active low)
//   new_e/new_b/a_hcount/a_vcount/a_valid     : neighbour pixel stream in
//   dither_pixel/_hcount/_vcount/_valid       : quantized output
//   updated_pixel/_hcount/_valid              : next-row writeback strobe
// Build option: DITHER_2BIT_EN (see dither_quantizer).
module dither_engine
  import dither_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [8:0]  new_e,
  input  logic [8:0]  new_b,
  input  logic [10:0] a_hcount,
  input  logic [9:0]  a_vcount,
  input  logic        a_valid,
  output logic [7:0]  dither_pixel,
  output logic [10:0] dither_hcount,
  output logic [9:0]  dither_vcount,
  output logic        dither_valid,
  output logic [7:0]  updated_pixel,
  output logic [10:0] updated_hcount,
  output logic        updated_valid
);

  localparam logic [10:0] LAST_COL = 11'(FRAME_WIDTH - 1);
  localparam logic [9:0]  LAST_ROW = 10'(FRAME_HEIGHT - 1);

  // stage 1 input registers
  logic        s1_valid_q;
  logic [8:0]  s1_e_q, s1_b_q;
  logic [10:0] s1_h_q;
  logic [9:0]  s1_v_q;

  // diffusion state: acc_m1_q is next-row column x-1, acc_0_q column x,
  // both as seen just before pixel x is processed
  acc_t        carry_q, carry_d;
  acc_t        acc_m1_q, acc_m1_d;
  acc_t        acc_0_q, acc_0_d;
  logic [8:0]  nb_q, nb_d;
  logic        fresh_q, fresh_d;
  logic        flush_q, flush_d;

  // output registers
  logic [7:0]  dpix_q, dpix_d;
  logic [10:0] dh_q, dh_d;
  logic [9:0]  dv_q, dv_d;
  logic        dvalid_q, dvalid_d;
  logic [7:0]  upix_q, upix_d;
  logic [10:0] uh_q, uh_d;
  logic        uvalid_q, uvalid_d;

  // stage 2 combinational datapath
  logic               row_start, last_col, last_row;
  acc_t               carry_in;
  logic signed [13:0] v_sum, wb_sum, flush_sum;
  logic [7:0]         v_clamped, q;
  err_t               err;
  acc_t               t_right, t_dl, t_d, t_dr;
  acc_t               acc_m1, acc_0, acc_p1;

  always_comb begin
    // first pixel after reset is a row start whatever its column
    row_start = (s1_h_q == 11'd0) || fresh_q;
    last_col  = (s1_h_q == LAST_COL);
    last_row  = (s1_v_q == LAST_ROW);
    carry_in  = row_start ? '0 : carry_q;
    v_sum     = $signed({5'd0, s1_e_q}) + $signed({carry_in[12], carry_in});
  end

  assign v_clamped = clamp8(v_sum);

  dither_quantizer u_quant (
    .v_i   (v_clamped),
    .q_o   (q),
    .err_o (err)
  );

  always_comb begin
    t_right = diffuse(err, K_RIGHT);
    t_dl    = diffuse(err, K_DOWN_LEFT);
    t_d     = diffuse(err, K_DOWN);
    t_dr    = diffuse(err, K_DOWN_RIGHT);
    // row start: no x-1 neighbour, and stale accumulators are dropped
    acc_m1    = row_start ? '0 : (acc_m1_q + t_dl);
    acc_0     = (row_start ? '0 : acc_0_q) + t_d;
    acc_p1    = last_col ? '0 : t_dr;
    wb_sum    = $signed({5'd0, nb_q}) + $signed({acc_m1[12], acc_m1});
    // flush reads the state left by column FRAME_WIDTH-1 before any
    // coinciding row-start pixel overwrites it at this edge
    flush_sum = $signed({5'd0, nb_q}) + $signed({acc_m1_q[12], acc_m1_q});
  end

  always_comb begin
    carry_d  = carry_q;
    acc_m1_d = acc_m1_q;
    acc_0_d  = acc_0_q;
    nb_d     = nb_q;
    fresh_d  = fresh_q;
    flush_d  = 1'b0;
    dpix_d   = dpix_q;
    dh_d     = dh_q;
    dv_d     = dv_q;
    dvalid_d = s1_valid_q;
    upix_d   = upix_q;
    uh_d     = uh_q;
    uvalid_d = 1'b0;

    if (s1_valid_q) begin
      carry_d  = last_col ? '0 : t_right;
      acc_m1_d = acc_0;
      acc_0_d  = acc_p1;
      nb_d     = s1_b_q;
      fresh_d  = 1'b0;
      flush_d  = last_col && !last_row;
      dpix_d   = q;
      dh_d     = s1_h_q;
      dv_d     = s1_v_q;
    end

    // a flush can only coincide with a row-start pixel, which never writes back
    if (flush_q) begin
      uvalid_d = 1'b1;
      upix_d   = clamp8(flush_sum);
      uh_d     = LAST_COL;
    end else if (s1_valid_q && !row_start && !last_row) begin
      uvalid_d = 1'b1;
      upix_d   = clamp8(wb_sum);
      uh_d     = s1_h_q - 11'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid_q <= 1'b0;
      s1_e_q     <= '0;
      s1_b_q     <= '0;
      s1_h_q     <= '0;
      s1_v_q     <= '0;
      carry_q    <= '0;
      acc_m1_q   <= '0;
      acc_0_q    <= '0;
      nb_q       <= '0;
      fresh_q    <= 1'b1;
      flush_q    <= 1'b0;
      dpix_q     <= '0;
      dh_q       <= '0;
      dv_q       <= '0;
      dvalid_q   <= 1'b0;
      upix_q     <= '0;
      uh_q       <= '0;
      uvalid_q   <= 1'b0;
    end else begin
      s1_valid_q <= a_valid;
      if (a_valid) begin
        s1_e_q <= new_e;
        s1_b_q <= new_b;
        s1_h_q <= a_hcount;
        s1_v_q <= a_vcount;
      end
      carry_q  <= carry_d;
      acc_m1_q <= acc_m1_d;
      acc_0_q  <= acc_0_d;
      nb_q     <= nb_d;
      fresh_q  <= fresh_d;
      flush_q  <= flush_d;
      dpix_q   <= dpix_d;
      dh_q     <= dh_d;
      dv_q     <= dv_d;
      dvalid_q <= dvalid_d;
      upix_q   <= upix_d;
      uh_q     <= uh_d;
      uvalid_q <= uvalid_d;
    end
  end

  assign dither_pixel   = dpix_q;
  assign dither_hcount  = dh_q;
  assign dither_vcount  = dv_q;
  assign dither_valid   = dvalid_q;
  assign updated_pixel  = upix_q;
  assign updated_hcount = uh_q;
  assign updated_valid  = uvalid_q;

endmodule

// File: tb/tb_dither_engine.sv
module tb_dither_engine;

  localparam int W = 320;
  localparam int H = 240;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [8:0]  new_e = '0;
  logic [8:0]  new_b = '0;
  logic [10:0] a_hcount = '0;
  logic [9:0]  a_vcount = '0;
  logic        a_valid = 1'b0;
  logic [7:0]  dither_pixel;
  logic [10:0] dither_hcount;
  logic [9:0]  dither_vcount;
  logic        dither_valid;
  logic [7:0]  updated_pixel;
  logic [10:0] updated_hcount;
  logic        updated_valid;

  dither_engine dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .new_e          (new_e),
    .new_b          (new_b),
    .a_hcount       (a_hcount),
    .a_vcount       (a_vcount),
    .a_valid        (a_valid),
    .dither_pixel   (dither_pixel),
    .dither_hcount  (dither_hcount),
    .dither_vcount  (dither_vcount),
    .dither_valid   (dither_valid),
    .updated_pixel  (updated_pixel),
    .updated_hcount (updated_hcount),
    .updated_valid  (updated_valid)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  pix;
    logic [10:0] h;
    logic [9:0]  v;
    logic [31:0] t;
  } ev_t;

  ev_t dq[$];
  ev_t uq[$];

  int total = 0;
  int bad   = 0;
  int re[W], rb[W], xd[W], xu[W];
  int obs_d[W], obs_u[W];
  int lr_d = 0, lr_u = 0;
  bit lr_win = 1'b0;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic int clampi(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic int quant(input int v);
`ifdef DITHER_2BIT_EN
    if (v < 43) return 0;
    if (v < 128) return 85;
    if (v < 213) return 170;
    return 255;
`else
    return (v >= 128) ? 255 : 0;
`endif
  endfunction

  // whole-row reference: errors scattered into a next-row array
  function automatic void model_row();
    int acc[W];
    int carry, v, q, err;
    carry = 0;
    foreach (acc[i]) acc[i] = 0;
    for (int x = 0; x < W; x++) begin
      v = clampi(re[x] + ((x == 0) ? 0 : carry));
      q = quant(v);
      err = v - q;
      xd[x] = q;
      carry = (err * 7) >>> 4;
      if (x > 0) acc[x-1] += (err * 3) >>> 4;
      acc[x] += (err * 5) >>> 4;
      if (x < W - 1) acc[x+1] += (err * 1) >>> 4;
    end
    for (int x = 0; x < W; x++) xu[x] = clampi(rb[x] + acc[x]);
  endfunction

  task automatic rand_row();
    for (int i = 0; i < W; i++) begin
      re[i] = int'($urandom_range(0, 511));
      rb[i] = int'($urandom_range(0, 511));
    end
  endtask

  task automatic clr_obs();
    for (int i = 0; i < W; i++) begin
      obs_d[i] = -1;
      obs_u[i] = -1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in); #1;
      a_valid = 1'b0;
    end
  endtask

  task automatic drive_row(input int y, input int stop_at, input int bub_at,
                           input int bub_len, input bit bub_rand);
    ev_t e;
    model_row();
    for (int x = 0; x < stop_at; x++) begin
      if (x == bub_at) idle(bub_len);
      if (bub_rand && $urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
      @(negedge clk_in); #1;
      a_valid  = 1'b1;
      new_e    = 9'(re[x]);
      new_b    = 9'(rb[x]);
      a_hcount = 11'(x);
      a_vcount = 10'(y);
      e.pix = 8'(xd[x]); e.h = 11'(x); e.v = 10'(y); e.t = cyc + 2;
      dq.push_back(e);
      if (y != H - 1) begin
        if (x > 0) begin
          e.pix = 8'(xu[x-1]); e.h = 11'(x - 1); e.v = '0; e.t = cyc + 2;
          uq.push_back(e);
        end
        if (x == W - 1) begin
          e.pix = 8'(xu[W-1]); e.h = 11'(W - 1); e.v = '0; e.t = cyc + 3;
          uq.push_back(e);
        end
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dpix"}, int'(dither_pixel), 0);
    chk({tag, "_dh"}, int'(dither_hcount), 0);
    chk({tag, "_dv"}, int'(dither_vcount), 0);
    chk({tag, "_dvalid"}, int'(dither_valid), 0);
    chk({tag, "_upix"}, int'(updated_pixel), 0);
    chk({tag, "_uh"}, int'(updated_hcount), 0);
    chk({tag, "_uvalid"}, int'(updated_valid), 0);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an output
  always @(negedge clk_in) begin
    ev_t g, e;
    if (rst_in) begin
      if (dither_valid) begin
        g.pix = dither_pixel; g.h = dither_hcount; g.v = dither_vcount; g.t = cyc;
        if (int'(dither_hcount) < W) obs_d[dither_hcount] = int'(dither_pixel);
        if (dither_vcount == 10'(H - 1)) lr_d++;
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL dither_extra got pix=%0d h=%0d v=%0d cyc=%0d",
                   g.pix, g.h, g.v, g.t);
        end else begin
          e = dq.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL dither got pix=%0d h=%0d v=%0d cyc=%0d want pix=%0d h=%0d v=%0d cyc=%0d",
                     g.pix, g.h, g.v, g.t, e.pix, e.h, e.v, e.t);
          end
        end
      end
      if (updated_valid) begin
        g.pix = updated_pixel; g.h = updated_hcount; g.v = '0; g.t = cyc;
        if (int'(updated_hcount) < W) obs_u[updated_hcount] = int'(updated_pixel);
        if (lr_win) lr_u++;
        total++;
        if (uq.size() == 0) begin
          bad++;
          $display("FAIL updated_extra got pix=%0d h=%0d cyc=%0d", g.pix, g.h, g.t);
        end else begin
          e = uq.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL updated got pix=%0d h=%0d cyc=%0d want pix=%0d h=%0d cyc=%0d",
                     g.pix, g.h, g.t, e.pix, e.h, e.t);
          end
        end
      end
    end
  end

  initial begin
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    chk_zero_outputs("por");
    rst_in = 1'b1;

    // single-pixel error on row 0
    clr_obs();
    for (int i = 0; i < W; i++) begin
      re[i] = 0;
      rb[i] = 100;
    end
    re[0] = 200;
    drive_row(0, W, -1, 0, 1'b0);
    idle(4);
`ifndef DITHER_2BIT_EN
    chk("single_d0", obs_d[0], 255);
    chk("single_d1", obs_d[1], 0);
    chk("single_u0", obs_u[0], 82);
    chk("single_u1", obs_u[1], 96);
`endif

    // random rows back-to-back, then fixed and random bubbles
    rand_row(); drive_row(1, W, -1, 0, 1'b0);
    rand_row(); drive_row(2, W, -1, 0, 1'b0);
    rand_row(); drive_row(3, W, 150, 5, 1'b0);
    rand_row(); drive_row(4, W, -1, 0, 1'b1);
    idle(4);

    // right edge
    clr_obs();
    for (int i = 0; i < W; i++) begin
      re[i] = 0;
      rb[i] = 100;
    end
    re[W-1] = 255;
    drive_row(5, W, -1, 0, 1'b0);
    idle(4);
    chk("edge_d319", obs_d[W-1], 255);
    chk("edge_flush319", obs_u[W-1], 100);

    // reset in the middle of a row
    rand_row();
    drive_row(6, 100, -1, 0, 1'b0);
    @(negedge clk_in); #1;
    rst_in  = 1'b0;
    a_valid = 1'b0;
    dq.delete();
    uq.delete();
    #1;
    chk_zero_outputs("midrst");
    idle(2);
    @(negedge clk_in); #1;
    rst_in = 1'b1;
    rand_row(); drive_row(7, W, -1, 0, 1'b0);

    // constant input level
    clr_obs();
    for (int i = 0; i < W; i++) begin
      re[i] = 100;
      rb[i] = int'($urandom_range(0, 511));
    end
    drive_row(8, W, -1, 0, 1'b0);
    idle(4);
`ifdef DITHER_2BIT_EN
    chk("const_d0", obs_d[0], 85);
    chk("const_d1", obs_d[1], 85);
`else
    chk("const_d0", obs_d[0], 0);
    chk("const_d1", obs_d[1], 255);
`endif

    // last row: dither only, no writebacks
    lr_d = 0;
    lr_u = 0;
    lr_win = 1'b1;
    rand_row(); drive_row(H - 1, W, -1, 0, 1'b1);
    idle(5);
    lr_win = 1'b0;
    chk("lastrow_dither_count", lr_d, W);
    chk("lastrow_updated_count", lr_u, 0);

    chk("dither_queue_left", dq.size(), 0);
    chk("updated_queue_left", uq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dither_engine.md
# dither_engine

Floyd-Steinberg error-diffusion engine for the grayscale preprocessing path. It consumes the neighbour pixel stream produced by the line buffers: the current-row pixel with accumulated error, and the raw next-row pixel. For each pixel it emits a quantized output pixel, and it writes the error-updated next-row pixel back to the line buffers so that row is corrected before it is dithered. It sits between the line buffers and the palette/LZW stage.

## Interface
- FRAME_WIDTH, 320: pixels per row.
- FRAME_HEIGHT, 240: rows per frame.
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- new_e  input  9  current-row pixel at a_hcount, including previously diffused error; unsigned 0..511.
- new_b  input  9  raw next-row pixel at a_hcount; unsigned.
- a_hcount  input  11  column of the input pixel.
- a_vcount  input  10  row of the input pixel.
- a_valid  input  1  input pixel valid. No backpressure.
- dither_pixel  output  8  quantized pixel value.
- dither_hcount  output  11  column of dither_pixel.
- dither_vcount  output  10  row of dither_pixel.
- dither_valid  output  1  dither_pixel valid.
- updated_pixel  output  8  error-corrected next-row pixel, clamped to 0..255.
- updated_hcount  output  11  column of updated_pixel.
- updated_valid  output  1  write strobe to the line buffers.

## Operation
- Per valid input at column x, compute v = new_e + carry, where carry is 7/16 of the error from x-1. Clamp v to 0..255.
- Quantize, 1-bit mode: v >= 128 gives 255, otherwise 0.
- Error: err = v - q. err is signed 9-bit.
- Diffusion weights are err*k >>> 4, an arithmetic shift (floor). Products are signed 13-bit.
  - Right neighbour: k=7.
  - Next row x-1: k=3.
  - Next row x: k=5.
  - Next row x+1: k=1.
- Three next-row accumulators, acc_m1, acc_0 and acc_p1, shift left by one on each valid input. new_b is delayed by one valid pixel.
- Column x-1 is final once x is processed. At that point emit updated_pixel = clamp(new_b[x-1] + acc_m1), with updated_hcount = x-1.
- Column boundaries:
  - x=0: carry and all accumulators are forced to 0. The 3/16 term is discarded and no writeback is issued.
  - x=FRAME_WIDTH-1: the 7/16 and 1/16 terms are discarded.
  - After the last column: one flush writeback for column FRAME_WIDTH-1.
- Last row (a_vcount = FRAME_HEIGHT-1): updated_valid is never asserted. dither outputs are unaffected.
- Cycles with a_valid low are bubbles. All state holds and results are identical to a continuous stream.

## Timing
- Two-stage pipeline.
  - An input at cycle t produces dither_* at t+2.
  - The writeback for column x-1 appears at t+2.
- Flush writeback for column FRAME_WIDTH-1 appears one cycle after the writeback for FRAME_WIDTH-2.
- If the next row's x=0 arrives back-to-back, its dither output coincides with the flush. There is no conflict, because x=0 issues no writeback.
- All outputs are registered. Reset value of every output is 0.
- Reset asserted mid-row clears carry, accumulators, the flush-pending flag and the pipeline valids immediately. The first post-reset input is treated as a row start.

## Configuration
- DITHER_2BIT_EN defined: 4-level quantizer with outputs {0,85,170,255}.
  - Thresholds: v < 43 gives 0; v < 128 gives 85; v < 213 gives 170; otherwise 255.
  - err is computed as for 1-bit mode.
- DITHER_2BIT_EN undefined: 1-bit quantizer as described under Operation.

## Structure
- dither_pkg holds:
  - diffusion weights (7, 3, 5, 1) and shift amount 4;
  - the thresholds and quantized levels;
  - typedef err_t, signed [8:0];
  - typedef acc_t, signed [12:0];
  - a clamp-to-8-bit function.
- Sub-module dither_quantizer: v in, q and err out. It holds the macro-selected level logic.

## Test plan
- Single-pixel error: row 0 with new_e = 200 at x=0 and 0 elsewhere, new_b = 100 everywhere.
  - Required: dither(0) = 255, err = -55.
  - Required: dither(1) = 0, since carry -25 is clamped to 0.
  - Required: updated(0) = 82 and updated(1) = 96.
- Right edge: new_e = 255 at x=319 and new_b = 100.
  - Required: dither(319) = 255, with no carry into the next row's x=0.
  - Required: the flush writeback hcount 319 = 100 arrives one cycle after hcount 318.
- Last row: a_vcount = 239 for a full row.
  - Required: updated_valid stays 0 and 320 dither_valid pulses occur.
- Bubbles: a random row with a_valid deasserted for 5 cycles at x=150.
  - Required: the dither and updated streams match the continuous run bit-for-bit.
- Reset: assert rst_in at x=100.
  - Required: all outputs read 0 on the same cycle.
  - Required: after release, the next row behaves as for a fresh x=0.
- DITHER_2BIT_EN with constant new_e = 100: first pixel dither = 85, err = 15, carry = 6.
